arb_grant_dispatch: RTL and testbench

//  Downstream stage of the 4-way round-robin arbiter. Consumes the one-hot grant and grant-valid,

---
 rtl/arb_pkg.sv | 13 +
 rtl/arb_disp_fifo.sv | 39 +++
 rtl/arb_grant_dispatch.sv | 79 +++++++
 tb/tb_arb_grant_dispatch.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// arb_pkg: shared constants and grant-decoding helpers for the arbiter dispatch stage
package arb_pkg;
  localparam int NUM_CLIENTS = 4;
  localparam int SRC_W = 2;

  function automatic logic [SRC_W-1:0] onehot_to_idx(input logic [3:0] oh);
    return {oh[3] | oh[2], oh[3] | oh[1]};
  endfunction

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction
endpackage

// File: rtl/arb_disp_fifo.sv
// arb_disp_fifo: small synchronous FIFO with registered storage and occupancy count
module arb_disp_fifo #(
  parameter int W = 34,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] count_q;

  // storage and pointers; pointers wrap naturally since DEPTH is a power of 2
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= wdata;
        wr_q <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  assign head = mem_q[rd_q];
  assign count = count_q;
endmodule

// File: rtl/arb_grant_dispatch.sv
// arb_grant_dispatch: validates arbiter grants, queues the winner's payload and keeps statistics
module arb_grant_dispatch import arb_pkg::*; #(
  parameter int DW = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [3:0]                   gnt,
  input  logic                         gnt_valid,
  input  logic [NUM_CLIENTS*DW-1:0]    cli_data,
  output logic [3:0]                   cli_ack,
  output logic                         out_valid,
  output logic [DW-1:0]                out_data,
  output logic [SRC_W-1:0]             out_src,
  input  logic                         out_ready,
  output logic [NUM_CLIENTS*CNT_W-1:0] acc_cnt,
  output logic [CNT_W-1:0]             drop_cnt,
  output logic                         err_onehot
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [CW-1:0] count;
  logic [SRC_W+DW-1:0] head;
  logic [SRC_W-1:0] src;
  logic [3:0] ack_mask_q;
  logic [CNT_W-1:0] acc_q [NUM_CLIENTS];
  logic [CNT_W-1:0] drop_q;
  logic err_q;
  logic legal, illegal, pop, space, masked, push, drop;

  // grant checking, stale re-grant masking and push/ack decision
  always_comb begin
    legal = gnt_valid && is_onehot4(gnt);
    illegal = gnt_valid ? !is_onehot4(gnt) : |gnt;
    src = onehot_to_idx(gnt);
    pop = out_valid && out_ready;
    space = (count < CW'(DEPTH)) || pop;
    masked = |(gnt & ack_mask_q);
    push = legal && space && !masked;
    drop = legal && (masked || !space);
    cli_ack = push ? gnt : 4'd0;
  end

  arb_disp_fifo #(.W(SRC_W + DW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata ({src, cli_data[int'(src)*DW +: DW]}),
    .head  (head),
    .count (count)
  );

  // ack mask, sticky protocol error and saturating statistics
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_mask_q <= '0;
      drop_q <= '0;
      err_q <= 1'b0;
      for (int i = 0; i < NUM_CLIENTS; i++) acc_q[i] <= '0;
    end else begin
      ack_mask_q <= cli_ack;
      err_q <= err_q | illegal;
      if (drop && drop_q != '1) drop_q <= drop_q + 1'b1;
      for (int i = 0; i < NUM_CLIENTS; i++)
        if (cli_ack[i] && acc_q[i] != '1) acc_q[i] <= acc_q[i] + 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_CLIENTS; i++) begin : g_acc
    assign acc_cnt[i*CNT_W +: CNT_W] = acc_q[i];
  end

  assign out_valid = count != '0;
  assign out_data = out_valid ? head[DW-1:0] : '0;
  assign out_src = out_valid ? head[DW +: SRC_W] : '0;
  assign drop_cnt = drop_q;
  assign err_onehot = err_q;
endmodule

// File: tb/tb_arb_grant_dispatch.sv
// tb_arb_grant_dispatch: directed self-checking bench for the grant dispatch stage
module tb_arb_grant_dispatch;
  localparam int DW = 32;
  localparam int CNT_W = 4;
  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] gnt;
  logic gnt_valid;
  logic [4*DW-1:0] cli_data;
  logic [3:0] cli_ack;
  logic out_valid;
  logic [DW-1:0] out_data;
  logic [1:0] out_src;
  logic out_ready;
  logic [4*CNT_W-1:0] acc_cnt;
  logic [CNT_W-1:0] drop_cnt;
  logic err_onehot;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  arb_grant_dispatch #(.DW(DW), .DEPTH(2), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .gnt        (gnt),
    .gnt_valid  (gnt_valid),
    .cli_data   (cli_data),
    .cli_ack    (cli_ack),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_src    (out_src),
    .out_ready  (out_ready),
    .acc_cnt    (acc_cnt),
    .drop_cnt   (drop_cnt),
    .err_onehot (err_onehot)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic grant(input logic [3:0] g, input logic v);
    gnt = g;
    gnt_valid = v;
  endtask

  function automatic logic [CNT_W-1:0] acc(input int i);
    return acc_cnt[i*CNT_W +: CNT_W];
  endfunction

  initial begin
    rst_n = 1'b0;
    grant(4'd0, 1'b0);
    out_ready = 1'b0;
    cli_data = {32'hD3D3_0003, 32'hA5A5_0002, 32'hD1D1_0001, 32'hD0D0_0000};
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_src", out_src, 0);
    chk("rst_cli_ack", cli_ack, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    chk("rst_acc_cnt", acc_cnt, 0);
    chk("rst_err", err_onehot, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    // single grant to client 2
    grant(4'b0100, 1'b1);
    out_ready = 1'b1;
    #1 chk("t1_ack", cli_ack, 4'b0100);
    tick();
    grant(4'd0, 1'b0);
    chk("t1_valid", out_valid, 1);
    chk("t1_data", out_data, 32'hA5A5_0002);
    chk("t1_src", out_src, 2);
    chk("t1_acc2", acc(2), 1);
    tick();
    chk("t1_drained", out_valid, 0);
    // backpressure: clients 0,1 accepted, client 2 dropped
    out_ready = 1'b0;
    grant(4'b0001, 1'b1);
    #1 chk("t2_ack0", cli_ack, 4'b0001);
    tick();
    grant(4'b0010, 1'b1);
    #1 chk("t2_ack1", cli_ack, 4'b0010);
    tick();
    grant(4'b0100, 1'b1);
    #1 chk("t2_ack2_blocked", cli_ack, 4'b0000);
    tick();
    grant(4'd0, 1'b0);
    chk("t2_drop", drop_cnt, 1);
    chk("t2_head_src", out_src, 0);
    chk("t2_head_data", out_data, 32'hD0D0_0000);
    tick();
    chk("t2_head_stable", out_src, 0);
    chk("t2_head_stable_data", out_data, 32'hD0D0_0000);
    out_ready = 1'b1;
    tick();
    chk("t2_pop2_src", out_src, 1);
    chk("t2_pop2_data", out_data, 32'hD1D1_0001);
    tick();
    chk("t2_empty", out_valid, 0);
    // full FIFO accepts a push when popping in the same cycle
    out_ready = 1'b0;
    grant(4'b0001, 1'b1);
    tick();
    grant(4'b0010, 1'b1);
    tick();
    grant(4'b1000, 1'b1);
    out_ready = 1'b1;
    #1 chk("t3_ack3", cli_ack, 4'b1000);
    tick();
    grant(4'd0, 1'b0);
    out_ready = 1'b0;
    chk("t3_head_src", out_src, 1);
    chk("t3_acc3", acc(3), 1);
    chk("t3_drop_unchanged", drop_cnt, 1);
    out_ready = 1'b1;
    tick();
    chk("t3_second_src", out_src, 3);
    chk("t3_second_valid", out_valid, 1);
    tick();
    chk("t3_empty", out_valid, 0);
    // stale re-grant is absorbed by the ack mask
    grant(4'b0001, 1'b1);
    #1 chk("t4_ack_first", cli_ack, 4'b0001);
    tick();
    #1 chk("t4_ack_stale", cli_ack, 4'b0000);
    chk("t4_one_entry", out_src, 0);
    tick();
    grant(4'd0, 1'b0);
    chk("t4_drop", drop_cnt, 2);
    chk("t4_single_entry", out_valid, 0);
    chk("t4_acc0", acc(0), 3);
    chk("t4_acc1", acc(1), 2);
    // protocol error and async reset
    grant(4'b0110, 1'b1);
    #1 chk("t5_no_ack", cli_ack, 4'b0000);
    tick();
    grant(4'd0, 1'b0);
    chk("t5_err", err_onehot, 1);
    chk("t5_no_push", out_valid, 0);
    chk("t5_no_count", drop_cnt, 2);
    tick();
    chk("t5_err_sticky", err_onehot, 1);
    grant(4'b0010, 1'b0);
    tick();
    grant(4'd0, 1'b0);
    chk("t5_err_gv0", err_onehot, 1);
    out_ready = 1'b0;
    grant(4'b0001, 1'b1);
    tick();
    grant(4'd0, 1'b0);
    chk("t5_pending", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", out_valid, 0);
    chk("t5_rst_data", out_data, 0);
    chk("t5_rst_err", err_onehot, 0);
    chk("t5_rst_drop", drop_cnt, 0);
    chk("t5_rst_acc", acc_cnt, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("t5_empty_after", out_valid, 0);
    // saturation of the per-client accept counter
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      grant(4'b1000, 1'b1);
      tick();
      grant(4'd0, 1'b0);
      tick();
    end
    chk("t6_acc3_sat", acc(3), 15);
    chk("t6_drop", drop_cnt, 0);
    chk("t6_err", err_onehot, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
